// File: rtl/ysyx_23060025_ifu_fetch.sv
// Instruction-fetch engine: issues one AXI4-Lite read per pc, holds the
// fetched word for decode and exposes its state to the PC counter.
module ysyx_23060025_ifu_fetch #(
  parameter int unsigned ADDR_LEN    = 32,
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_LEN-1:0] pc_i,
  input  logic                last_finish_i,
  output logic [ADDR_LEN-1:0] araddr_o,
  output logic                arvalid_o,
  input  logic                arready_i,
  input  logic [31:0]         rdata_i,
  input  logic [1:0]          rresp_i,
  input  logic                rvalid_i,
  output logic                rready_o,
  output logic [31:0]         inst_o,
  output logic                inst_valid_o,
  output logic                fetch_err_o,
  output logic                timeout_o,
  output logic [1:0]          con_state_o
);

  localparam int unsigned    CntW   = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC);

  // Encoding is visible to the PC counter, which decodes StWait (2'b10).
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StAddr = 2'b01,
    StData = 2'b11,
    StWait = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       inst_q, inst_d;
  logic              fetch_err_q, fetch_err_d;
  logic              timeout_q, timeout_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              busy;

  // Next-state, captured instruction/error and the timeout watchdog.
  always_comb begin
    state_d     = state_q;
    inst_d      = inst_q;
    fetch_err_d = fetch_err_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    busy        = (state_q == StAddr) || (state_q == StData);

    unique case (state_q)
      StIdle: state_d = StAddr;
      StAddr: if (arready_i) state_d = StData;
      StData: begin
        if (rvalid_i) begin
          state_d     = StWait;
          inst_d      = (rresp_i != 2'b00) ? NOP_INST : rdata_i;
          fetch_err_d = (rresp_i != 2'b00);
        end
      end
      StWait: if (last_finish_i) state_d = StAddr;
      default: state_d = StIdle;
    endcase

    // Counter restarts for every new transaction and saturates at CntMax.
    if ((state_d == StAddr) && (state_q != StAddr)) begin
      cnt_d = '0;
    end else if (busy && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Only flags the slow fetch; the transaction itself keeps waiting.
    timeout_d = timeout_q | (cnt_d == CntMax);
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      inst_q      <= 32'h0;
      fetch_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      inst_q      <= inst_d;
      fetch_err_q <= fetch_err_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
    end
  end

  // Handshakes decode straight from the state register, so they can never overlap.
  always_comb begin
    araddr_o     = pc_i;
    arvalid_o    = (state_q == StAddr);
    rready_o     = (state_q == StData);
    inst_valid_o = (state_q == StWait);
    inst_o       = inst_q;
    fetch_err_o  = fetch_err_q;
    timeout_o    = timeout_q;
    con_state_o  = state_q;
  end

endmodule

// File: tb/tb_ysyx_23060025_ifu_fetch.sv
// Self-checking bench for the fetch engine: directed scenarios followed by
// randomized stalls/responses, checked against a transaction-level model.
module tb_ysyx_23060025_ifu_fetch;

  localparam int          Tmo = 16;
  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_i;
  logic        last_finish_i;
  logic [31:0] araddr_o;
  logic        arvalid_o;
  logic        arready_i;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rvalid_i;
  logic        rready_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        fetch_err_o;
  logic        timeout_o;
  logic [1:0]  con_state_o;

  ysyx_23060025_ifu_fetch dut (
    .clock        (clock),
    .reset        (reset),
    .pc_i         (pc_i),
    .last_finish_i(last_finish_i),
    .araddr_o     (araddr_o),
    .arvalid_o    (arvalid_o),
    .arready_i    (arready_i),
    .rdata_i      (rdata_i),
    .rresp_i      (rresp_i),
    .rvalid_i     (rvalid_i),
    .rready_o     (rready_o),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .fetch_err_o  (fetch_err_o),
    .timeout_o    (timeout_o),
    .con_state_o  (con_state_o)
  );

  always #5 clock = ~clock;

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  // Model state: what decode should currently see.
  logic [31:0] exp_inst = 32'h0;
  logic        exp_err  = 1'b0;
  logic        sticky   = 1'b0;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // One read: address phase stalls ast cycles, data phase stalls dst cycles.
  // Entered one step after an edge with the DUT expected in the address phase.
  task automatic do_fetch(input int ast, input int dst, input logic [1:0] resp,
                          input logic [31:0] data);
    int k;
    k = 0;
    for (int i = 0; i <= ast; i++) begin
      arready_i     = (i == ast);
      rvalid_i      = 1'b0;
      last_finish_i = 1'($urandom_range(0, 1));
      #1;
      chk32("addr_state", 32'(con_state_o), 32'h1);
      chk1("arvalid", arvalid_o, 1'b1);
      chk32("araddr", araddr_o, pc_i);
      chk1("rready_in_addr", rready_o, 1'b0);
      chk1("timeout_addr", timeout_o, sticky || (k >= Tmo));
      tick();
      k++;
    end
    arready_i = 1'b0;
    for (int j = 0; j <= dst; j++) begin
      rvalid_i      = (j == dst);
      rresp_i       = (j == dst) ? resp : 2'($urandom_range(0, 3));
      rdata_i       = (j == dst) ? data : $urandom;
      last_finish_i = 1'($urandom_range(0, 1));
      #1;
      chk32("data_state", 32'(con_state_o), 32'h3);
      chk1("rready", rready_o, 1'b1);
      chk1("arvalid_in_data", arvalid_o, 1'b0);
      chk1("timeout_data", timeout_o, sticky || (k >= Tmo));
      tick();
      k++;
    end
    rvalid_i      = 1'b0;
    last_finish_i = 1'b0;
    exp_inst = (resp != 2'b00) ? Nop : data;
    exp_err  = (resp != 2'b00);
    sticky   = sticky || (k >= Tmo);
    #1;
    chk32("wait_state", 32'(con_state_o), 32'h2);
    chk1("inst_valid", inst_valid_o, 1'b1);
    chk32("inst", inst_o, exp_inst);
    chk1("fetch_err", fetch_err_o, exp_err);
    chk1("timeout_done", timeout_o, sticky);
  endtask

  // Sit in the wait state nwait cycles, then retire and hand over the next pc.
  task automatic finish_wait(input int nwait, input logic [31:0] next_pc);
    for (int w = 0; w < nwait; w++) begin
      tick();
      chk32("wait_hold_state", 32'(con_state_o), 32'h2);
      chk32("wait_hold_inst", inst_o, exp_inst);
      chk1("wait_no_ar", arvalid_o, 1'b0);
    end
    last_finish_i = 1'b1;
    tick();
    last_finish_i = 1'b0;
    pc_i          = next_pc;
  endtask

  initial begin
    int          t0;
    logic [1:0]  r;
    reset         = 1'b1;
    pc_i          = 32'h8000_0000;
    last_finish_i = 1'b0;
    arready_i     = 1'b0;
    rdata_i       = 32'h0;
    rresp_i       = 2'b00;
    rvalid_i      = 1'b0;
    tick();
    tick();
    chk32("rst_state", 32'(con_state_o), 32'h0);
    chk1("rst_arvalid", arvalid_o, 1'b0);
    chk1("rst_rready", rready_o, 1'b0);
    chk32("rst_inst", inst_o, 32'h0);
    chk1("rst_err", fetch_err_o, 1'b0);
    chk1("rst_timeout", timeout_o, 1'b0);

    // 1: first fetch with a zero-wait memory lands in the wait state on cycle 3.
    reset = 1'b0;
    cyc   = 0;
    tick();
    do_fetch(0, 0, 2'b00, 32'h0000_0413);
    chk32("first_latency", 32'(cyc), 32'd3);

    // 2: address phase stalled three cycles.
    finish_wait(1, 32'h8000_0004);
    do_fetch(3, 0, 2'b00, 32'h1234_5678);

    // 3: error response substitutes the NOP, then an OKAY fetch clears the flag.
    finish_wait(0, 32'h8000_0008);
    do_fetch(0, 1, 2'b10, 32'hDEAD_BEEF);
    chk32("err_nop", inst_o, 32'h0000_0013);
    finish_wait(2, 32'h8000_000C);
    do_fetch(1, 0, 2'b00, 32'h0000_0513);
    chk1("err_cleared", fetch_err_o, 1'b0);

    // 4: steady-state latency from retire to the next valid word is 2 cycles.
    finish_wait(0, 32'h8000_0010);
    t0 = cyc;
    do_fetch(0, 0, 2'b00, 32'h0010_0093);
    chk32("steady_latency", 32'(cyc - t0), 32'd2);

    // 6: a 20-cycle address stall trips the watchdog, which then stays set.
    finish_wait(1, 32'h8000_0014);
    do_fetch(20, 0, 2'b00, 32'h0020_0113);
    finish_wait(0, 32'h8000_0018);
    do_fetch(0, 0, 2'b00, 32'h0030_0193);
    chk1("timeout_sticky", timeout_o, 1'b1);

    // 5: reset while the read is outstanding.
    finish_wait(0, 32'h8000_001C);
    arready_i = 1'b1;
    #1;
    chk1("pre_rst_arvalid", arvalid_o, 1'b1);
    tick();
    arready_i = 1'b0;
    reset     = 1'b1;
    #1;
    chk1("pre_rst_rready", rready_o, 1'b1);
    tick();
    chk32("mid_rst_state", 32'(con_state_o), 32'h0);
    chk1("mid_rst_rready", rready_o, 1'b0);
    chk1("mid_rst_arvalid", arvalid_o, 1'b0);
    chk32("mid_rst_inst", inst_o, 32'h0);
    chk1("mid_rst_timeout", timeout_o, 1'b0);
    chk1("mid_rst_valid", inst_valid_o, 1'b0);
    sticky   = 1'b0;
    exp_inst = 32'h0;
    exp_err  = 1'b0;
    reset    = 1'b0;
    tick();
    do_fetch(0, 0, 2'b00, 32'h0040_0213);

    // Randomized stalls, responses and retire delays.
    for (int n = 0; n < 40; n++) begin
      finish_wait($urandom_range(0, 2), pc_i + 32'd4);
      r = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      do_fetch($urandom_range(0, 9), $urandom_range(0, 9), r, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the sequence never completes.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

endmodule
